// File: rtl/store_buffer.sv
// In-order write-back store buffer: queues {address, data} stores from the core
// and offers the oldest one to data memory with a valid/ready handshake.
// Optional store-to-load forwarding is built when STORE_BUF_FWD_EN is defined.

module store_buffer_entry #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [DW-1:0] wrData,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  // Payload only; occupancy lives in the pointers, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      addr <= wrAddr;
      data <= wrData;
    end
  end
endmodule

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     MemWrite,
  input  logic [AW-1:0]            DataAdr,
  input  logic [DW-1:0]            WriteData,
  output logic                     Stall,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
`ifdef STORE_BUF_FWD_EN
  ,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic          full, push, pop;

  logic [DEPTH-1:0]         entWr;
  logic [DEPTH-1:0][AW-1:0] entAddr;
  logic [DEPTH-1:0][DW-1:0] entData;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  // No full-bypass: a pop on the same edge never frees a slot for a push.
  assign push  = MemWrite & ~full;
  assign pop   = ~empty & mem_ready;
  assign Stall = MemWrite & full;
  assign count = cnt;

  assign mem_valid = ~empty;
  assign mem_addr  = empty ? '0 : entAddr[head];
  assign mem_wdata = empty ? '0 : entData[head];

  always_comb begin
    entWr = '0;
    if (push) entWr[tail] = 1'b1;
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gEnt
      store_buffer_entry #(.AW(AW), .DW(DW)) uEnt (
        .clk    (clk),
        .wrEn   (entWr[g]),
        .wrAddr (DataAdr),
        .wrData (WriteData),
        .addr   (entAddr[g]),
        .data   (entData[g])
      );
    end
  endgenerate

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Walk oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < cnt) && (entAddr[head + PW'(k)] == DataAdr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entData[head + PW'(k)];
      end
    end
  end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed + random bench for store_buffer; a queue model predicts the memory
// write stream, occupancy and handshake outputs every cycle.

module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWrite;
  logic [AW-1:0] DataAdr;
  logic [DW-1:0] WriteData;
  logic          Stall;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [CW-1:0] count;
  logic          empty;
`ifdef STORE_BUF_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } st_t;

  st_t q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .Stall     (Stall),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .count     (count),
    .empty     (empty)
`ifdef STORE_BUF_FWD_EN
    ,
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check against the model, then advance the model.
  task automatic cycle(input logic mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic rdy, input logic rst);
    int  n;
    bit  doPop, doPush;
    @(negedge clk);
    MemWrite = mw; DataAdr = a; WriteData = d; mem_ready = rdy; reset = rst;
    #1;
    n = q.size();
    chk("count", count, n);
    chk("empty", empty, n == 0);
    chk("mem_valid", mem_valid, n != 0);
    chk("Stall", Stall, mw && n == DEPTH);
    if (n == 0) begin
      chk("idle_addr", mem_addr, 0);
      chk("idle_wdata", mem_wdata, 0);
    end else begin
      chk("head_addr", mem_addr, q[0].addr);
      chk("head_wdata", mem_wdata, q[0].data);
    end
`ifdef STORE_BUF_FWD_EN
    begin
      logic          h = 1'b0;
      logic [DW-1:0] fd = '0;
      foreach (q[i]) if (q[i].addr == a) begin h = 1'b1; fd = q[i].data; end
      chk("fwd_hit", fwd_hit, h);
      chk("fwd_data", fwd_data, fd);
    end
`endif
    doPop  = (n != 0) && rdy;
    doPush = mw && (n < DEPTH);
    if (rst) q.delete();
    else begin
      if (doPop)  void'(q.pop_front());
      if (doPush) q.push_back('{addr: a, data: d});
    end
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    cycle(0, 0, 0, 0, 0);  // post-reset state

    // Single store, one-cycle latency, drains next edge
    cycle(1, 100, 7, 1, 0);
    cycle(0, 0, 0, 1, 0);
    chk("lat_addr_seen", q.size(), 0);
    cycle(0, 0, 0, 1, 0);

    // Fill while memory is busy, fifth store stalls until a slot frees
    for (int i = 0; i < 4; i++) cycle(1, 96 + 4 * i, i + 1, 0, 0);
    cycle(1, 112, 5, 0, 0);
    chk("full_stall", Stall, 1);
    cycle(1, 112, 5, 1, 0);  // pop but no push when full
    chk("no_bypass", Stall, 1);
    cycle(1, 112, 5, 1, 0);  // now accepted
    repeat (5) cycle(0, 0, 0, 1, 0);

    // count=2, simultaneous push/pop across pointer wrap
    cycle(1, 300, 1, 0, 0);
    cycle(1, 304, 2, 0, 0);
    cycle(1, 200, 9, 1, 0);
    chk("pushpop_cnt", count, 2);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, 400 + 4 * i, 20 + i, 1, 0);
    chk("wrap_cnt", count, 2);
    repeat (3) cycle(0, 0, 0, 1, 0);

    // Reset mid-drain discards everything
    for (int i = 0; i < 3; i++) cycle(1, 500 + 4 * i, 30 + i, 0, 0);
    cycle(1, 600, 99, 1, 1);
    cycle(0, 0, 0, 1, 0);
    chk("rst_cnt", count, 0);
    chk("rst_valid", mem_valid, 0);
    repeat (3) cycle(0, 0, 0, 1, 0);

    // Empty with mem_ready toggling
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, i[0], 0);

`ifdef STORE_BUF_FWD_EN
    cycle(1, 100, 5, 0, 0);
    cycle(1, 100, 7, 0, 0);
    cycle(0, 100, 0, 0, 0);
    chk("fwd_young_hit", fwd_hit, 1);
    chk("fwd_young_data", fwd_data, 7);
    cycle(1, 104, 3, 0, 0);  // entry being written is not visible
    chk("fwd_miss_hit", fwd_hit, 0);
    repeat (4) cycle(0, 0, 0, 1, 0);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), {$urandom_range(0, 7), 2'b00}, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
    repeat (DEPTH + 2) cycle(0, 0, 0, 1, 0);
    chk("final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port MemWrite  input  1  core store request this cycle.
REQ-007 SHALL have port DataAdr  input  AW  core store/load address.
REQ-008 SHALL have port WriteData  input  DW  core store data.
REQ-009 SHALL have port Stall  output  1  store not accepted; core holds request.
REQ-010 SHALL have port mem_valid  output  1  head entry offered to data memory.
REQ-011 SHALL have port mem_ready  input  1  data memory accepts head entry.
REQ-012 SHALL have port mem_addr  output  AW  head entry address.
REQ-013 SHALL have port mem_wdata  output  DW  head entry data.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-015 SHALL have port empty  output  1  count == 0.

Function
REQ-016 SHALL implement an in-order FIFO of {address, data} with head/tail pointers wrapping modulo DEPTH.
REQ-017 SHALL accept a push when MemWrite=1 and count<DEPTH; the entry is written at tail on that edge.
REQ-018 SHALL drive Stall = MemWrite & (count==DEPTH), combinationally; no push occurs while Stall=1.
REQ-019 SHALL NOT accept a push when full even if a pop occurs the same cycle (no full-bypass).
REQ-020 SHALL drive mem_valid = (count!=0); mem_addr/mem_wdata = head entry, and 0 when empty.
REQ-021 SHALL pop the head on an edge where mem_valid & mem_ready; head entry SHALL stay stable while mem_valid=1 and mem_ready=0.
REQ-022 SHALL have latency of one cycle: a store pushed on edge N appears on mem_* after edge N when buffer was empty; no combinational path from MemWrite to mem_*.
REQ-023 SHALL handle simultaneous push and pop (count not full): count unchanged, both pointers advance.
REQ-024 SHALL ignore mem_ready when empty (no pop, no underflow).
REQ-025 SHALL store DataAdr unmodified (no alignment masking); ordering of stores to memory SHALL equal acceptance order.
REQ-026 SHALL keep count saturating within 0..DEPTH under all input combinations.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, clear head, tail and count to 0; pending entries are discarded.
REQ-028 SHALL drive after reset: mem_valid=0, mem_addr=0, mem_wdata=0, count=0, empty=1, Stall=0 unless MemWrite with full (impossible after reset).
REQ-029 SHALL ignore MemWrite and mem_ready on a reset edge; a reset asserted mid-drain drops the in-flight entry without a pop.

Configuration
REQ-030 SHALL, with macro STORE_BUF_FWD_EN defined, add outputs fwd_hit (1) and fwd_data (DW): combinational match of DataAdr against all valid entries, fwd_hit=1 on any match, fwd_data = youngest matching entry's data, 0 when no hit.
REQ-031 SHALL, without STORE_BUF_FWD_EN, omit fwd_hit/fwd_data ports and all compare logic; all other behaviour identical.
REQ-032 SHALL exclude the entry being written on the current edge from forwarding (forwarding sees registered state only).

Verification
REQ-033 Empty, mem_ready=1, store addr 100 data 7 -> next cycle mem_valid=1, mem_addr=100, mem_wdata=7; following cycle empty=1.
REQ-034 mem_ready=0, stores to 96,100,104,108 data 1..4, fifth store 112 -> Stall=1 on fifth, count=4; raise mem_ready -> drained in order 96,100,104,108, then 112 accepted once count<4.
REQ-035 count=2, simultaneous push (200,9) and pop -> count stays 2, wrap-around across pointer index DEPTH-1 -> 0 preserves order.
REQ-036 count=3, reset pulsed one cycle with mem_ready=1 -> count=0, mem_valid=0, no further memory writes of discarded entries.
REQ-037 STORE_BUF_FWD_EN: stores (100,5) then (100,7) buffered, DataAdr=100 -> fwd_hit=1, fwd_data=7; DataAdr=104 -> fwd_hit=0, fwd_data=0.
REQ-038 Empty, mem_ready toggling with no stores for 10 cycles -> mem_valid=0 and count=0 throughout.
